traffic_phase_seq: RTL and testbench
====================================

TRAFFIC_PHASE_SEQ -- requirements
Module: traffic_phase_seq

Interface
REQ-001 The block SHALL have parameter GREEN_TICKS, default 20, meaning the dwell of each even phase in tick pulses (legal range 1..255).
REQ-002 The block SHALL have parameter YELLOW_TICKS, default 4, meaning the dwell of each odd phase in tick pulses (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: sequencer run request.
REQ-006 The block SHALL have port tick, input, 1 bit: one-clk-wide timebase pulse.
REQ-007 The block SHALL have port emerg, input, 1 bit: emergency override request.
REQ-008 The block SHALL have port emerg_phase, input, 3 bits: phase code to force during override.
REQ-009 The block SHALL have port i, output, 1 bit: lamp-decoder enable.
REQ-010 The block SHALL have ports s0, s1 and s2, each output, 1 bit: phase code to the lamp decoder, with s0 as MSB and s2 as LSB.
REQ-011 The block SHALL have port phase_step, output, 1 bit: one-clk pulse on every phase advance.

Function
REQ-012 The block SHALL implement states IDLE, RUN and HOLD, with phase register ph[2:0] and a dwell counter cnt[7:0].
REQ-013 All outputs SHALL be registered; {s0,s1,s2} SHALL equal ph in RUN, emerg_phase in HOLD, and 000 in IDLE.
REQ-014 In IDLE, i SHALL be 0; when en=1 the block SHALL enter RUN on the next edge with ph=0, cnt=GREEN_TICKS-1 and i=1.
REQ-015 In RUN with tick=1 and cnt!=0, the block SHALL decrement cnt; with tick=0 it SHALL hold cnt and ph.
REQ-016 In RUN with tick=1 and cnt==0, the block SHALL set ph=ph+1 (modulo 8, so 7 wraps to 0) and set phase_step=1 for that single cycle.
REQ-017 On that advance, cnt SHALL reload to GREEN_TICKS-1 if the new ph is even, or to YELLOW_TICKS-1 if it is odd.
REQ-018 Each phase SHALL therefore last exactly GREEN_TICKS or YELLOW_TICKS tick pulses; a full cycle SHALL last 4*(GREEN_TICKS+YELLOW_TICKS) ticks.
REQ-019 en=0 in RUN or HOLD SHALL return the block to IDLE on the next edge, with i=0, {s0,s1,s2}=000 and phase_step=0.
REQ-020 Priority SHALL be rst_n, then en=0, then emerg, then tick; a tick arriving in the same cycle as a higher-priority event SHALL be discarded.
REQ-021 phase_step SHALL be 0 in every cycle other than the advance cycle defined in REQ-016.

Reset
REQ-022 rst_n=0 sampled at a clk edge SHALL force state IDLE, ph=0, cnt=0, i=0, s0=s1=s2=0, phase_step=0, and the saved phase register to 0.
REQ-023 Reset asserted mid-phase or in HOLD SHALL discard all timing; after release with en=1, the block SHALL restart at ph=0 with a full green dwell.

Configuration
REQ-024 The macro TRAFFIC_SEQ_EMERG_EN SHALL compile the emergency override in or out.
REQ-025 With TRAFFIC_SEQ_EMERG_EN defined, emerg=1 in RUN SHALL enter HOLD on the next edge, save ph, freeze cnt, and drive {s0,s1,s2}=emerg_phase with i=1.
REQ-026 With TRAFFIC_SEQ_EMERG_EN defined, emerg_phase changes while in HOLD SHALL pass through on the next edge.
REQ-027 With TRAFFIC_SEQ_EMERG_EN defined, emerg=0 in HOLD SHALL return the block to RUN with the saved ph and cnt reloaded to the full dwell for that ph's parity.
REQ-028 With TRAFFIC_SEQ_EMERG_EN defined, emerg=1 while in IDLE SHALL be ignored.
REQ-029 Without TRAFFIC_SEQ_EMERG_EN, emerg and emerg_phase SHALL be ignored, HOLD SHALL not exist, and behaviour SHALL be identical to the macro-defined case with emerg tied to 0.

Verification (GREEN_TICKS=3, YELLOW_TICKS=1)
REQ-030 Reset then en=1 with no tick -> one clk later i=1 and s=000, and s SHALL remain 000 indefinitely.
REQ-031 en=1 with tick every clk -> s sequence 0,0,0,1,2,2,2,3,...,7,0, each value held for 3/1/3/1 ticks, with one phase_step pulse per change and 7 wrapping to 0.
REQ-032 en=1 with ticks spaced 5 clks apart -> phase 0 SHALL last exactly 3 ticks (15 clks) before s becomes 001.
REQ-033 With TRAFFIC_SEQ_EMERG_EN, during phase 2 after 1 tick, emerg=1 and emerg_phase=4 -> next clk s=100; after emerg=0, s=010 SHALL hold for 3 full ticks.
REQ-034 en=0 together with emerg=1 and tick=1 -> next clk i=0, s=000 and phase_step=0.
REQ-035 rst_n=0 for 1 clk during phase 5 -> next clk all outputs 0; after rst_n=1 with en=1, the sequence SHALL restart at s=000 with a 3-tick dwell.

Source files
------------

// File: rtl/traffic_phase_seq.sv
// rtl/traffic_phase_seq.sv - eight-phase traffic sequencer with tick-based green/yellow dwell.
// Optional emergency hold compiled in with TRAFFIC_SEQ_EMERG_EN.
module traffic_phase_seq #(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tick,
  input  logic       emerg,
  input  logic [2:0] emerg_phase,
  output logic       i,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       phase_step
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [7:0] GREEN_RELOAD  = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] YELLOW_RELOAD = 8'(YELLOW_TICKS - 1);

  state_e     state_q, state_d;
  logic [2:0] ph_q, ph_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] saved_q, saved_d;
  logic       i_q, i_d;
  logic [2:0] s_q, s_d;
  logic       step_q, step_d;
  logic [2:0] ph_inc;
  logic       emerg_req;
  logic [2:0] emerg_ph;

`ifdef TRAFFIC_SEQ_EMERG_EN
  assign emerg_req = emerg;
  assign emerg_ph  = emerg_phase;
`else
  assign emerg_req = 1'b0;
  assign emerg_ph  = 3'b000;
  wire unused_emerg = &{1'b0, emerg, emerg_phase};
`endif

  assign ph_inc = ph_q + 3'd1;

  // Even phases are green, odd phases are yellow.
  function automatic logic [7:0] reload_for(input logic [2:0] p);
    return p[0] ? YELLOW_RELOAD : GREEN_RELOAD;
  endfunction

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    saved_d = saved_q;
    i_d     = 1'b0;
    s_d     = 3'b000;
    step_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          ph_d    = 3'd0;
          cnt_d   = GREEN_RELOAD;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          ph_d    = 3'd0;
          cnt_d   = 8'd0;
        end else if (emerg_req) begin
          state_d = ST_HOLD;
          saved_d = ph_q;
        end else if (tick) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            ph_d   = ph_inc;
            cnt_d  = reload_for(ph_inc);
            step_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!en) begin
          state_d = ST_IDLE;
          ph_d    = 3'd0;
          cnt_d   = 8'd0;
        end else if (!emerg_req) begin
          // Resume the interrupted phase with a fresh full dwell.
          state_d = ST_RUN;
          ph_d    = saved_q;
          cnt_d   = reload_for(saved_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = 3'd0;
        cnt_d   = 8'd0;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      ST_RUN: begin
        i_d = 1'b1;
        s_d = ph_d;
      end
      ST_HOLD: begin
        i_d = 1'b1;
        s_d = emerg_ph;
      end
      default: begin
        i_d = 1'b0;
        s_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= 3'd0;
      cnt_q   <= 8'd0;
      saved_q <= 3'd0;
      i_q     <= 1'b0;
      s_q     <= 3'b000;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      saved_q <= saved_d;
      i_q     <= i_d;
      s_q     <= s_d;
      step_q  <= step_d;
    end
  end

  assign i          = i_q;
  assign s0         = s_q[2];
  assign s1         = s_q[1];
  assign s2         = s_q[0];
  assign phase_step = step_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// tb/tb_traffic_phase_seq.sv - scoreboard bench for traffic_phase_seq against a tick-counting phase model.
module tb_traffic_phase_seq;

  localparam int G = 3;
  localparam int Y = 1;
`ifdef TRAFFIC_SEQ_EMERG_EN
  localparam bit EMERG = 1'b1;
`else
  localparam bit EMERG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] emerg_phase = 3'd0;
  logic       i, s0, s1, s2, phase_step;

  always #5 clk = ~clk;

  traffic_phase_seq #(.GREEN_TICKS(G), .YELLOW_TICKS(Y)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .emerg(emerg),
    .emerg_phase(emerg_phase), .i(i), .s0(s0), .s1(s1), .s2(s2),
    .phase_step(phase_step)
  );

  typedef struct packed {
    logic       i;
    logic [2:0] s;
    logic       step;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   steps_seen = 0;
  int   steps_exp = 0;

  // Model: mode 0=idle 1=run 2=hold; elapsed counts ticks consumed in the current phase.
  int m_mode = 0;
  int m_phase = 0;
  int m_elapsed = 0;
  int m_hold_ph = 0;

  function automatic int dwell(input int p);
    return (p % 2 == 0) ? G : Y;
  endfunction

  task automatic drive(input logic r, input logic e, input logic t,
                       input logic em, input logic [2:0] ep);
    exp_t x;
    logic stp;
    @(negedge clk);
    #1;
    rst_n = r; en = e; tick = t; emerg = em; emerg_phase = ep;
    stp = 1'b0;
    if (!r) begin
      m_mode = 0; m_phase = 0; m_elapsed = 0; m_hold_ph = 0;
    end else if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_phase = 0; m_elapsed = 0; end
    end else if (!e) begin
      m_mode = 0;
    end else if (EMERG && em) begin
      m_mode = 2; m_hold_ph = int'(ep);
    end else if (m_mode == 2) begin
      m_mode = 1; m_elapsed = 0;
    end else if (t) begin
      m_elapsed++;
      if (m_elapsed == dwell(m_phase)) begin
        m_phase = (m_phase + 1) % 8;
        m_elapsed = 0;
        stp = 1'b1;
        steps_exp++;
      end
    end
    x.i    = (m_mode != 0);
    x.s    = (m_mode == 1) ? 3'(m_phase) : (m_mode == 2) ? 3'(m_hold_ph) : 3'd0;
    x.step = stp;
    exp_q.push_back(x);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        exp_t got;
        e = exp_q.pop_front();
        got = {i, s0, s1, s2, phase_step};
        n_tests++;
        if (phase_step === 1'b1) steps_seen++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t got i=%b s=%b step=%b want i=%b s=%b step=%b",
                   $time, got.i, got.s, got.step, e.i, e.s, e.step);
        end
      end
    end
  end

  initial begin
    logic emr;
    logic [2:0] epr;
    int guard;
    // Reset state
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    // Enabled without ticks stays in phase 0
    repeat (20) drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    // Tick every clock: full wrap twice
    repeat (40) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    // Disable, then ticks spaced five clocks apart
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 60; k++) drive(1'b1, 1'b1, (k % 5 == 4), 1'b0, 3'd0);
    // en=0 coinciding with emerg and tick
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    // Reset asserted during phase 5
    guard = 0;
    while (m_phase != 5 && guard < 200) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      guard++;
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    repeat (12) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    // Emergency hold in phase 2 after one tick
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    guard = 0;
    while (!(m_phase == 2 && m_elapsed == 1) && guard < 200) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      guard++;
    end
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    repeat (6) drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    // Emergency while idle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd7);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
    // Randomized traffic
    emr = 1'b0;
    epr = 3'd0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) emr = ~emr;
      if ($urandom_range(0, 3) == 0) epr = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 99) != 0),
            ($urandom_range(0, 2) == 0), emr, epr);
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    n_tests++;
    if (steps_seen != steps_exp) begin
      n_fail++;
      $display("FAIL step_count got %0d want %0d", steps_seen, steps_exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
